// File: rtl/diffeq_host.sv
// diffeq_host: host-side sequencer for the 4-bit signed diffeq solver.
// Loads u/x/dx/a into the solver, runs it, returns y or a watchdog abort.
module diffeq_host #(
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_u,
    input  logic [3:0] cmd_x,
    input  logic [3:0] cmd_dx,
    input  logic [3:0] cmd_a,
    output logic [3:0] input_bits,
    output logic       signals1,
    output logic       signals0,
    output logic       start,
    input  logic [3:0] y,
    input  logic       valid,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_y,
    output logic       res_timeout,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_U,
        LOAD_X,
        LOAD_DX,
        LOAD_A,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [3:0]       x_q;
    logic [3:0]       dx_q;
    logic [3:0]       a_q;
    logic [CNT_W-1:0] wdog;

    assign cmd_ready = (state == IDLE);

    // u goes straight into the load register at accept; x/dx/a wait in x_q..a_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_q         <= '0;
            dx_q        <= '0;
            a_q         <= '0;
            wdog        <= '0;
            input_bits  <= '0;
            signals1    <= 1'b0;
            signals0    <= 1'b0;
            start       <= 1'b0;
            res_valid   <= 1'b0;
            res_y       <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        x_q        <= cmd_x;
                        dx_q       <= cmd_dx;
                        a_q        <= cmd_a;
                        input_bits <= cmd_u;
                        signals1   <= 1'b0;
                        signals0   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= LOAD_U;
                    end
                end
                LOAD_U: begin
                    input_bits <= x_q;
                    signals1   <= 1'b0;
                    signals0   <= 1'b1;
                    state      <= LOAD_X;
                end
                LOAD_X: begin
                    input_bits <= dx_q;
                    signals1   <= 1'b1;
                    signals0   <= 1'b0;
                    state      <= LOAD_DX;
                end
                LOAD_DX: begin
                    input_bits <= a_q;
                    signals1   <= 1'b1;
                    signals0   <= 1'b1;
                    state      <= LOAD_A;
                end
                LOAD_A: begin
                    input_bits <= '0;
                    signals1   <= 1'b0;
                    signals0   <= 1'b0;
                    start      <= 1'b1;
                    wdog       <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    wdog <= wdog + 1'b1;
                    // a result landing on the last watchdog cycle still counts
                    if (valid) begin
                        res_y       <= y;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        start       <= 1'b0;
                        state       <= DONE;
                    end else if (wdog == WD_LAST) begin
                        res_y       <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        start       <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diffeq_host.sv
// tb_diffeq_host: directed bench with a result scoreboard for diffeq_host.
// dut uses the default watchdog, dut8 a watchdog of 8 cycles.
module tb_diffeq_host;

    logic       clk;
    logic       rst_n;
    logic [3:0] cu, cx, cdx, ca;

    logic       cmd_valid, cmd_ready, start, valid, res_valid, res_ready;
    logic       res_timeout, busy, s1, s0;
    logic [3:0] ib, yv, res_y;

    logic       cmd_valid8, cmd_ready8, start8, valid8, res_valid8, res_ready8;
    logic       res_timeout8, busy8, s1_8, s0_8;
    logic [3:0] ib8, yv8, res_y8;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb[$];

    diffeq_host dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_u(cu), .cmd_x(cx), .cmd_dx(cdx), .cmd_a(ca),
        .input_bits(ib), .signals1(s1), .signals0(s0),
        .start(start), .y(yv), .valid(valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_timeout(res_timeout), .busy(busy)
    );

    diffeq_host #(.TIMEOUT_CYCLES(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
        .cmd_u(cu), .cmd_x(cx), .cmd_dx(cdx), .cmd_a(ca),
        .input_bits(ib8), .signals1(s1_8), .signals0(s0_8),
        .start(start8), .y(yv8), .valid(valid8),
        .res_valid(res_valid8), .res_ready(res_ready8),
        .res_y(res_y8), .res_timeout(res_timeout8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL sim_time_limit observed=expired required=finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input int w);
        logic [4:0] e;
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("res_y", w == 0 ? res_y : res_y8, e[3:0]);
            check("res_timeout", w == 0 ? res_timeout : res_timeout8, e[4]);
        end
    endtask

    // drives one command, checks the four load cycles, returns in RUN cycle 1
    task automatic load_cmd(input int w, input logic [3:0] u, x, dx, a);
        logic [3:0] ops [4];
        ops[0] = u; ops[1] = x; ops[2] = dx; ops[3] = a;
        cu = u; cx = x; cdx = dx; ca = a;
        if (w == 0) cmd_valid = 1'b1;
        else cmd_valid8 = 1'b1;
        check("cmd_ready_pre", w == 0 ? cmd_ready : cmd_ready8, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_valid8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("load_sel", w == 0 ? {s1, s0} : {s1_8, s0_8}, i);
            check("load_data", w == 0 ? ib : ib8, ops[i]);
            check("load_start", w == 0 ? start : start8, 0);
            tick();
        end
        check("start_rise", w == 0 ? start : start8, 1);
        check("run_bits", w == 0 ? ib : ib8, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 0; cmd_valid8 = 0; valid = 0; valid8 = 0;
        res_ready = 0; res_ready8 = 0; yv = 0; yv8 = 0;
        cu = 0; cx = 0; cdx = 0; ca = 0;

        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_bits", ib, 0);
        check("rst_sel", {s1, s0}, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_y", res_y, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst8_busy", busy8, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_start", start, 0);
            check("idle_cmd_ready", cmd_ready, 1);
        end

        // normal completion after 40 RUN cycles
        res_ready = 1'b1;
        sb.push_back({1'b0, 4'b1101});
        load_cmd(0, 4'd1, 4'd0, 4'd1, 4'd5);
        for (int i = 1; i < 40; i++) begin
            tick();
            check("run_start", start, 1);
            check("run_res_valid", res_valid, 0);
        end
        valid = 1'b1;
        yv = 4'b1101;
        tick();
        valid = 1'b0;
        yv = 4'd0;
        check("done_res_valid", res_valid, 1);
        check("done_start", start, 0);
        check("done_cmd_ready", cmd_ready, 0);
        pop_check(0);
        tick();
        check("ack_res_valid", res_valid, 0);
        check("ack_cmd_ready", cmd_ready, 1);

        // backpressure in DONE
        res_ready = 1'b0;
        sb.push_back({1'b0, 4'h6});
        load_cmd(0, 4'h7, 4'h8, 4'h2, 4'h3);
        valid = 1'b1;
        yv = 4'h6;
        tick();
        valid = 1'b0;
        yv = 4'h0;
        check("bp_res_valid", res_valid, 1);
        pop_check(0);
        for (int i = 0; i < 10; i++) begin
            cmd_valid = (i == 4);
            cu = 4'hF;
            tick();
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_y", res_y, 4'h6);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_bits", ib, 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        check("bp_release", res_valid, 0);
        check("bp_idle_busy", busy, 0);
        tick();
        check("bp_no_accept", busy, 0);

        // watchdog expiry on dut8
        res_ready8 = 1'b1;
        sb.push_back({1'b1, 4'h0});
        load_cmd(1, 4'h2, 4'h3, 4'h4, 4'h5);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("to_wait_valid", res_valid8, 0);
            check("to_wait_start", start8, 1);
        end
        tick();
        check("to_res_valid", res_valid8, 1);
        check("to_start", start8, 0);
        pop_check(1);
        tick();
        check("to_idle", cmd_ready8, 1);

        // valid on the last watchdog cycle wins
        sb.push_back({1'b0, 4'h9});
        load_cmd(1, 4'h1, 4'h1, 4'h1, 4'h1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("tie_wait_valid", res_valid8, 0);
        end
        valid8 = 1'b1;
        yv8 = 4'h9;
        tick();
        valid8 = 1'b0;
        yv8 = 4'h0;
        check("tie_res_valid", res_valid8, 1);
        pop_check(1);
        tick();

        // reset during LOAD_DX
        cu = 4'h1; cx = 4'h2; cdx = 4'h3; ca = 4'h4;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("mid_ld_sel", {s1, s0}, 2);
        rst_n = 1'b0;
        tick();
        check("rld_start", start, 0);
        check("rld_busy", busy, 0);
        check("rld_res_valid", res_valid, 0);
        check("rld_bits", ib, 0);
        check("rld_sel", {s1, s0}, 0);
        rst_n = 1'b1;
        tick();

        // reset during RUN
        load_cmd(0, 4'h5, 4'h6, 4'h7, 4'h8);
        tick();
        rst_n = 1'b0;
        tick();
        check("rrun_start", start, 0);
        check("rrun_busy", busy, 0);
        check("rrun_res_valid", res_valid, 0);
        rst_n = 1'b1;
        tick();

        // fresh command after aborts
        res_ready = 1'b1;
        sb.push_back({1'b0, 4'h4});
        load_cmd(0, 4'hA, 4'h3, 4'hF, 4'h1);
        valid = 1'b1;
        yv = 4'h4;
        tick();
        valid = 1'b0;
        check("fresh_res_valid", res_valid, 1);
        pop_check(0);
        tick();
        check("fresh_idle", cmd_ready, 1);
        check("sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
